// File: rtl/instr_fetch_pkg.sv
// Shared CPU fetch definitions: FSM state encoding, default reset PC and
// halt word, and the word-alignment helper used on redirects.
package instr_fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FETCH   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_HALT    = 2'd3
  } fetch_state_e;

  localparam logic [31:0] DEFAULT_RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_HALT_WORD = 32'hFFFF_FFFF;

  // Clears the byte-offset bits so the PC always points at a whole word.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Bundle between the control unit / instruction memory and the fetcher.
//
// Handshake: fetch_req and redirect_valid are single-cycle requests that are
// accepted only while the fetcher is idle (busy=0 and halted=0); anything
// presented while busy or halted is dropped, never queued. Each accepted
// fetch_req produces exactly one fetch_done pulse three cycles later, in the
// same cycle the new ir/pc become visible. The memory side has no handshake:
// im_dout must hold the word at im_addr one cycle after im_addr is presented.
interface instr_fetch_if
  import instr_fetch_pkg::*;
#(
  parameter int ADDR_W = 10
) ();

  logic              fetch_req;
  logic              redirect_valid;
  logic [31:0]       redirect_pc;
  logic [ADDR_W-1:0] im_addr;
  logic [31:0]       im_dout;
  logic [31:0]       ir;
  logic [31:0]       pc;
  logic [31:0]       pc_plus4;
  logic              fetch_done;
  logic              busy;
  logic              halted;
  logic [31:0]       instr_count;
  fetch_state_e      state;        // debug view of the fetch FSM

  // Control unit and memory side
  modport master (
    output fetch_req, redirect_valid, redirect_pc, im_dout,
    input  im_addr, ir, pc, pc_plus4, fetch_done, busy, halted,
           instr_count, state
  );

  // Fetch unit side
  modport slave (
    input  fetch_req, redirect_valid, redirect_pc, im_dout,
    output im_addr, ir, pc, pc_plus4, fetch_done, busy, halted,
           instr_count, state
  );

endinterface

// File: rtl/instr_fetch_pc_reg.sv
// Program counter register: loads an aligned redirect target or advances by
// one word; a load wins if both are requested (they never coincide in use).
module instr_fetch_pc_reg
  import instr_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_i,
  input  logic [31:0] load_pc_i,
  input  logic        inc_i,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o
);

  logic [31:0] pc_q;
  logic [31:0] pc_d;

  assign pc_o       = pc_q;
  assign pc_plus4_o = pc_q + 32'd4;

  // Next-PC selection: redirect, sequential advance, or hold
  always_comb begin
    pc_d = pc_q;
    if (load_i) begin
      pc_d = align_word(load_pc_i);
    end else if (inc_i) begin
      pc_d = pc_q + 32'd4;
    end
  end

  // PC state, reset to the (aligned) boot address
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= align_word(RESET_PC);
    end else begin
      pc_q <= pc_d;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Multi-cycle instruction fetch initiator. Presents pc to a synchronous-read
// instruction memory, waits one cycle for the registered read, latches the
// word into ir and advances pc. The all-ones halt word parks the fetcher
// until reset.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int          ADDR_W    = 10,
  parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter logic [31:0] HALT_WORD = DEFAULT_HALT_WORD
) (
  input  logic          clk,
  input  logic          rst_n,
  instr_fetch_if.slave  bus
);

  fetch_state_e state_q;
  logic [31:0]  ir_q;
  logic         fetch_done_q;
  logic         halted_q;
  logic [31:0]  instr_count_q;

  logic [31:0]  pc;
  logic [31:0]  pc_plus4;
  logic         is_halt;
  logic         pc_load;
  logic         pc_inc;

  assign is_halt = (bus.im_dout == HALT_WORD);
  // Redirects only land while idle; a same-cycle fetch_req then uses the new PC.
  assign pc_load = (state_q == ST_IDLE) && bus.redirect_valid;
  assign pc_inc  = (state_q == ST_CAPTURE) && !is_halt;

  instr_fetch_pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (pc_load),
    .load_pc_i  (bus.redirect_pc),
    .inc_i      (pc_inc),
    .pc_o       (pc),
    .pc_plus4_o (pc_plus4)
  );

  // Fetch sequencing FSM with registered ir, done pulse, halt flag and count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      ir_q          <= '0;
      fetch_done_q  <= 1'b0;
      halted_q      <= 1'b0;
      instr_count_q <= '0;
    end else begin
      fetch_done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.fetch_req) begin
            state_q <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          // Memory registers the addressed word at the end of this cycle.
          state_q <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          ir_q         <= bus.im_dout;
          fetch_done_q <= 1'b1;
          if (is_halt) begin
            halted_q <= 1'b1;
            state_q  <= ST_HALT;
          end else begin
            instr_count_q <= instr_count_q + 32'd1;
            state_q       <= ST_IDLE;
          end
        end
        ST_HALT: begin
          state_q <= ST_HALT;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.im_addr     = pc[ADDR_W+1:2];
  assign bus.ir          = ir_q;
  assign bus.pc          = pc;
  assign bus.pc_plus4    = pc_plus4;
  assign bus.fetch_done  = fetch_done_q;
  assign bus.busy        = (state_q == ST_FETCH) || (state_q == ST_CAPTURE);
  assign bus.halted      = halted_q;
  assign bus.instr_count = instr_count_q;
  assign bus.state       = state_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios with literal expectations, then
// randomized request traffic, all compared every cycle against a
// transaction-level model of the fetcher.
module tb_instr_fetch;

  localparam int          AW   = 10;
  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // ---------------- DUTs and memories ----------------
  instr_fetch_if #(.ADDR_W(AW)) if1 ();
  instr_fetch_if #(.ADDR_W(AW)) if2 ();

  instr_fetch #(
    .ADDR_W    (AW),
    .RESET_PC  (32'h0000_0000),
    .HALT_WORD (HALT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if1.slave)
  );

  // Second instance booting at the top of the memory to exercise the wrap.
  instr_fetch #(
    .ADDR_W    (AW),
    .RESET_PC  (32'h0000_0FFC),
    .HALT_WORD (HALT)
  ) dut_wrap (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if2.slave)
  );

  logic [31:0] mem [1024];

  always @(posedge clk) if1.im_dout <= mem[if1.im_addr];
  always @(posedge clk) if2.im_dout <= mem[if2.im_addr];

  // ---------------- scoreboard bookkeeping ----------------
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  bit cmp_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%08h required=%08h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A fetch accepted at cycle c completes two edges later; while a fetch is
  // outstanding or the machine is halted, requests are dropped.
  logic [31:0] m_pc, m_ir, m_count;
  bit          m_halted, m_done, m_pending;
  int unsigned cyc, done_at;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pc      <= 32'h0;
      m_ir      <= 32'h0;
      m_count   <= 32'h0;
      m_halted  <= 1'b0;
      m_done    <= 1'b0;
      m_pending <= 1'b0;
      cyc       <= 0;
      done_at   <= 0;
      exp_q.delete();
    end else begin
      cyc    <= cyc + 1;
      m_done <= 1'b0;
      if (m_pending) begin
        if (cyc == done_at) begin
          m_ir      <= exp_q[0];
          m_done    <= 1'b1;
          m_pending <= 1'b0;
          if (exp_q[0] == HALT) begin
            m_halted <= 1'b1;
          end else begin
            m_pc    <= m_pc + 32'd4;
            m_count <= m_count + 32'd1;
          end
          void'(exp_q.pop_front());
        end
      end else if (!m_halted) begin
        if (if1.redirect_valid) m_pc <= {if1.redirect_pc[31:2], 2'b00};
        if (if1.fetch_req) begin
          m_pending <= 1'b1;
          done_at   <= cyc + 2;
          if (if1.redirect_valid) exp_q.push_back(mem[if1.redirect_pc[AW+1:2]]);
          else                    exp_q.push_back(mem[m_pc[AW+1:2]]);
        end
      end
    end
  end

  // Per-cycle comparison of every observable output against the model
  always @(negedge clk) begin
    if (cmp_en) begin
      check("pc",          if1.pc,                  m_pc);
      check("pc_plus4",    if1.pc_plus4,            m_pc + 32'd4);
      check("im_addr",     32'(if1.im_addr),        32'(m_pc[AW+1:2]));
      check("ir",          if1.ir,                  m_ir);
      check("instr_count", if1.instr_count,         m_count);
      check("fetch_done",  32'(if1.fetch_done),     32'(m_done));
      check("busy",        32'(if1.busy),           32'(m_pending));
      check("halted",      32'(if1.halted),         32'(m_halted));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic fetch_op(input bit redir, input logic [31:0] rpc);
    if1.fetch_req      = 1'b1;
    if1.redirect_valid = redir;
    if1.redirect_pc    = rpc;
    step();
    if1.fetch_req      = 1'b0;
    if1.redirect_valid = 1'b0;
    step();
    step();
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem[i] = ($urandom_range(0, 15) == 0) ? HALT : ($urandom & 32'hFFFF_FFFE);
    end
    mem[0]    = 32'h2406_0014;
    mem[1]    = 32'h2405_0001;
    mem[11]   = 32'h14C4_FFF8;
    mem[12]   = 32'h0000_1111;
    mem[13]   = 32'h2222_3333;
    mem[14]   = HALT;
    mem[1023] = 32'h1234_5678;

    if1.fetch_req = 1'b0; if1.redirect_valid = 1'b0; if1.redirect_pc = 32'h0;
    if2.fetch_req = 1'b0; if2.redirect_valid = 1'b0; if2.redirect_pc = 32'h0;
    rst_n = 1'b0;
    step();
    step();
    cmp_en = 1'b1;

    // Reset state
    check("rst_pc",      if1.pc, 32'h0);
    check("rst_ir",      if1.ir, 32'h0);
    check("rst_done",    32'(if1.fetch_done), 32'h0);
    check("rst_busy",    32'(if1.busy), 32'h0);
    check("rst_count",   if1.instr_count, 32'h0);
    check("rst_im_addr", 32'(if1.im_addr), 32'h0);
    check("wrap_rst_im_addr", 32'(if2.im_addr), 32'd1023);
    rst_n = 1'b1;
    step();

    // Boot at 0xFFC: word 1023, then pc 0x1000 addresses word 0 again
    if2.fetch_req = 1'b1;
    step();
    if2.fetch_req = 1'b0;
    check("wrap_fetch_im_addr", 32'(if2.im_addr), 32'd1023);
    step();
    step();
    check("wrap_pc",      if2.pc, 32'h0000_1000);
    check("wrap_im_addr", 32'(if2.im_addr), 32'd0);
    check("wrap_ir",      if2.ir, 32'h1234_5678);
    if2.fetch_req = 1'b1;
    step();
    if2.fetch_req = 1'b0;
    step();
    step();
    check("wrap_pc2", if2.pc, 32'h0000_1004);
    check("wrap_ir2", if2.ir, 32'h2406_0014);

    // Two sequential fetches from reset
    fetch_op(1'b0, 32'h0);
    check("f1_done",  32'(if1.fetch_done), 32'h1);
    check("f1_ir",    if1.ir, 32'h2406_0014);
    check("f1_pc",    if1.pc, 32'h4);
    check("f1_count", if1.instr_count, 32'd1);
    step();
    check("f1_done_drop", 32'(if1.fetch_done), 32'h0);
    fetch_op(1'b0, 32'h0);
    check("f2_ir",    if1.ir, 32'h2405_0001);
    check("f2_pc",    if1.pc, 32'h8);
    check("f2_count", if1.instr_count, 32'd2);

    // Misaligned redirect together with a fetch
    if1.fetch_req = 1'b1; if1.redirect_valid = 1'b1; if1.redirect_pc = 32'h0000_002F;
    step();
    if1.fetch_req = 1'b0; if1.redirect_valid = 1'b0;
    check("rd_im_addr", 32'(if1.im_addr), 32'd11);
    check("rd_busy",    32'(if1.busy), 32'h1);
    step();
    step();
    check("rd_ir", if1.ir, 32'h14C4_FFF8);
    check("rd_pc", if1.pc, 32'h30);

    // Requests while busy are dropped
    if1.fetch_req = 1'b1;
    step();
    if1.fetch_req = 1'b1;           // arrives in FETCH
    step();
    if1.fetch_req = 1'b0;
    if1.redirect_valid = 1'b1;      // arrives in CAPTURE
    if1.redirect_pc = 32'h0000_0200;
    step();
    if1.redirect_valid = 1'b0;
    check("ign_done", 32'(if1.fetch_done), 32'h1);
    check("ign_pc",   if1.pc, 32'h34);
    check("ign_ir",   if1.ir, 32'h0000_1111);
    step();
    step();
    check("ign_idle",  32'(if1.busy), 32'h0);
    check("ign_pc2",   if1.pc, 32'h34);
    check("ign_count", if1.instr_count, 32'd4);

    // Reset during CAPTURE discards the in-flight word
    if1.fetch_req = 1'b1;
    step();
    if1.fetch_req = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    check("arst_pc",   if1.pc, 32'h0);
    check("arst_ir",   if1.ir, 32'h0);
    check("arst_done", 32'(if1.fetch_done), 32'h0);
    step();
    rst_n = 1'b1;
    step();
    step();
    step();
    check("arst_ir_after", if1.ir, 32'h0);
    check("arst_count",    if1.instr_count, 32'h0);

    // 32-bit PC wrap through a misaligned redirect at the top of memory
    fetch_op(1'b1, 32'hFFFF_FFFE);
    check("pwrap_ir", if1.ir, 32'h1234_5678);
    check("pwrap_pc", if1.pc, 32'h0);

    // Halt word: pc and count hold, later requests ignored
    fetch_op(1'b1, 32'h0000_0038);
    check("halt_flag",  32'(if1.halted), 32'h1);
    check("halt_done",  32'(if1.fetch_done), 32'h1);
    check("halt_pc",    if1.pc, 32'h38);
    check("halt_count", if1.instr_count, 32'd1);
    check("halt_ir",    if1.ir, HALT);
    fetch_op(1'b1, 32'h0000_0000);
    check("halt_busy",  32'(if1.busy), 32'h0);
    check("halt_nodone",32'(if1.fetch_done), 32'h0);
    check("halt_pc2",   if1.pc, 32'h38);
    reset_pulse();

    // Randomized traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      if ((m_halted && $urandom_range(0, 3) == 0) || $urandom_range(0, 199) == 0) begin
        reset_pulse();
      end
      if1.fetch_req      = ($urandom_range(0, 2) == 0);
      if1.redirect_valid = ($urandom_range(0, 3) == 0);
      if1.redirect_pc    = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 4095));
      step();
    end
    if1.fetch_req = 1'b0;
    if1.redirect_valid = 1'b0;
    step();
    step();
    cmp_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
